// File: rtl/inference_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Package  : nn_eval_pkg
// Brief    : Shared constants, FSM state type and one-hot helper for scoring.
// Revision : 1.0
// ============================================================================
package nn_eval_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int LBL_W       = $clog2(NUM_CLASSES);
    localparam int PCT_SCALE   = 100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        DIVIDE = 3'd2,
        REPORT = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Out-of-range labels map to an all-zero vector.
    function automatic logic [NUM_CLASSES-1:0] onehot(input logic [LBL_W-1:0] lbl);
        logic [NUM_CLASSES-1:0] v;
        v = '0;
        if (int'(lbl) < NUM_CLASSES) v[lbl] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inference_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Interface : inference_scoreboard_if
// Brief     : Valid/ready hand-off of a decision vector and its label.
// Revision  : 1.0
// ============================================================================
interface inference_scoreboard_if import nn_eval_pkg::*; ();

    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_CLASSES-1:0] obtained_output;
    logic [LBL_W-1:0]       label;

    modport master (output in_valid, output obtained_output, output label, input in_ready);
    modport slave  (input in_valid, input obtained_output, input label, output in_ready);

endinterface
`default_nettype wire

// File: rtl/inference_scoreboard_acc_divider.sv
`default_nettype none
// ============================================================================
// Module   : acc_divider
// Brief    : Fixed-latency restoring divider, one quotient bit per cycle.
// Revision : 1.0
// ============================================================================
module acc_divider #(
    parameter int DIV_W = 15,
    parameter int DVS_W = 8,
    parameter int Q_W   = 9
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_start,
    input  wire logic             i_abort,
    input  wire logic [DIV_W-1:0] i_dividend,
    input  wire logic [DVS_W-1:0] i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [Q_W-1:0]        o_quotient
);

    localparam int ITER_W = $clog2(DIV_W + 1);

    logic [DVS_W-1:0]  rem_q, rem_d, dvs_q, dvs_d;
    logic [DIV_W-1:0]  dq_q, dq_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic [DVS_W-1:0]  w_rem_src, w_dvs_src;
    logic [DIV_W-1:0]  w_dq_src;
    logic [DVS_W:0]    w_trial;
    logic              w_ge;

    // dq holds the unconsumed dividend bits on the left and the quotient
    // bits shifting in from the right; the first step happens on start.
    always_comb begin
        w_rem_src = i_start ? '0 : rem_q;
        w_dq_src  = i_start ? i_dividend : dq_q;
        w_dvs_src = i_start ? i_divisor : dvs_q;
        w_trial   = {w_rem_src, w_dq_src[DIV_W-1]};
        w_ge      = (w_trial >= {1'b0, w_dvs_src});

        rem_d  = rem_q;
        dq_d   = dq_q;
        dvs_d  = dvs_q;
        iter_d = iter_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (i_abort) begin
            busy_d = 1'b0;
            iter_d = '0;
        end else if (i_start || busy_q) begin
            rem_d  = w_ge ? DVS_W'(w_trial - {1'b0, w_dvs_src}) : w_trial[DVS_W-1:0];
            dq_d   = {w_dq_src[DIV_W-2:0], w_ge};
            dvs_d  = w_dvs_src;
            iter_d = i_start ? ITER_W'(DIV_W - 1) : iter_q - 1'b1;
            busy_d = (iter_d != '0);
            done_d = (iter_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dq_q   <= '0;
            dvs_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dq_q   <= dq_d;
            dvs_q  <= dvs_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_quotient = dq_q[Q_W-1:0];

endmodule
`default_nettype wire

// File: rtl/inference_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : inference_scoreboard
// Brief    : Scores each inference against its label, tracks accuracy %.
// Revision : 1.0
// ============================================================================
module inference_scoreboard import nn_eval_pkg::*; #(
    parameter int MAX_INPUTS = 200,
    parameter int ACC_W      = 9,
    parameter int CNT_W      = $clog2(MAX_INPUTS + 1),
    parameter int DIV_W      = CNT_W + 7
) (
    input  wire logic              clk,
    input  wire logic              rst_overall_n,
    input  wire logic              clear,
    inference_scoreboard_if.slave  in_if,
    output logic [NUM_CLASSES-1:0] expected_output,
    output logic [CNT_W-1:0]       correct_count,
    output logic [CNT_W-1:0]       count,
    output logic [ACC_W-1:0]       accuracy,
    output logic                   begin_next,
    output logic                   label_err,
    output logic                   all_done
);

    state_t                 state_q, state_d;
    logic [NUM_CLASSES-1:0] obt_q, obt_d, exp_q, exp_d;
    logic [LBL_W-1:0]       lbl_q, lbl_d;
    logic [CNT_W-1:0]       count_q, count_d, correct_q, correct_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic                   lerr_q, lerr_d, bnext_q, bnext_d;
    logic                   rdy_q, rdy_d, all_done_q, all_done_d;

    logic                   w_in_range, w_hit;
    logic                   w_div_start, w_div_abort, w_div_busy, w_div_done;
    logic [DIV_W-1:0]       w_dividend;
    logic [ACC_W-1:0]       w_quo;

    always_comb begin
        state_d     = state_q;
        obt_d       = obt_q;
        lbl_d       = lbl_q;
        count_d     = count_q;
        correct_d   = correct_q;
        acc_d       = acc_q;
        exp_d       = exp_q;
        lerr_d      = lerr_q;
        bnext_d     = 1'b0;
        w_div_start = 1'b0;
        w_div_abort = 1'b0;
        w_in_range  = (int'(lbl_q) < NUM_CLASSES);
        w_hit       = w_in_range && (obt_q == onehot(lbl_q));

        case (state_q)
            IDLE: begin
                if (in_if.in_valid && rdy_q) begin
                    obt_d   = in_if.obtained_output;
                    lbl_d   = in_if.label;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                count_d     = count_q + 1'b1;
                correct_d   = correct_q + CNT_W'(w_hit);
                exp_d       = onehot(lbl_q);
                lerr_d      = lerr_q | ~w_in_range;
                w_div_start = 1'b1;
                state_d     = DIVIDE;
            end
            DIVIDE: begin
                if (w_div_done && !w_div_busy) begin
                    acc_d   = w_quo;
                    bnext_d = 1'b1;
                    state_d = REPORT;
                end
            end
            REPORT:  state_d = (count_q == CNT_W'(MAX_INPUTS)) ? DONE : IDLE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        // Restart wins over everything, including a handshake or a finishing divide.
        if (clear) begin
            state_d     = IDLE;
            count_d     = '0;
            correct_d   = '0;
            acc_d       = '0;
            exp_d       = '0;
            lerr_d      = 1'b0;
            bnext_d     = 1'b0;
            w_div_start = 1'b0;
            w_div_abort = 1'b1;
        end

        rdy_d      = (state_d == IDLE);
        all_done_d = (state_d == DONE);
    end

    // Operands are taken from the freshly updated counters in CHECK.
    assign w_dividend = DIV_W'(correct_d) * DIV_W'(PCT_SCALE);

    acc_divider #(
        .DIV_W (DIV_W),
        .DVS_W (CNT_W),
        .Q_W   (ACC_W)
    ) u_acc_divider (
        .clk        (clk),
        .rst_n      (rst_overall_n),
        .i_start    (w_div_start),
        .i_abort    (w_div_abort),
        .i_dividend (w_dividend),
        .i_divisor  (count_d),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            state_q    <= IDLE;
            obt_q      <= '0;
            lbl_q      <= '0;
            count_q    <= '0;
            correct_q  <= '0;
            acc_q      <= '0;
            exp_q      <= '0;
            lerr_q     <= 1'b0;
            bnext_q    <= 1'b0;
            rdy_q      <= 1'b1;
            all_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            obt_q      <= obt_d;
            lbl_q      <= lbl_d;
            count_q    <= count_d;
            correct_q  <= correct_d;
            acc_q      <= acc_d;
            exp_q      <= exp_d;
            lerr_q     <= lerr_d;
            bnext_q    <= bnext_d;
            rdy_q      <= rdy_d;
            all_done_q <= all_done_d;
        end
    end

    assign in_if.in_ready  = rdy_q;
    assign expected_output = exp_q;
    assign correct_count   = correct_q;
    assign count           = count_q;
    assign accuracy        = acc_q;
    assign begin_next      = bnext_q;
    assign label_err       = lerr_q;
    assign all_done        = all_done_q;

endmodule
`default_nettype wire

// File: tb/tb_inference_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_inference_scoreboard
// Brief    : Randomized self-checking bench with an arithmetic accuracy model.
// Revision : 1.0
// ============================================================================
module tb_inference_scoreboard;
    import nn_eval_pkg::*;

    localparam int MAX_INPUTS = 200;
    localparam int ACC_W      = 9;
    localparam int CNT_W      = $clog2(MAX_INPUTS + 1);
    localparam int DIV_W      = CNT_W + 7;
    localparam int LAT        = 2 + DIV_W;

    logic clk = 1'b0;
    logic rst_overall_n = 1'b0;
    logic clear = 1'b0;

    inference_scoreboard_if sb_if ();

    logic [NUM_CLASSES-1:0] expected_output;
    logic [CNT_W-1:0]       correct_count, count;
    logic [ACC_W-1:0]       accuracy;
    logic                   begin_next, label_err, all_done;

    inference_scoreboard #(
        .MAX_INPUTS (MAX_INPUTS),
        .ACC_W      (ACC_W)
    ) dut (
        .clk             (clk),
        .rst_overall_n   (rst_overall_n),
        .clear           (clear),
        .in_if           (sb_if.slave),
        .expected_output (expected_output),
        .correct_count   (correct_count),
        .count           (count),
        .accuracy        (accuracy),
        .begin_next      (begin_next),
        .label_err       (label_err),
        .all_done        (all_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain tallies, accuracy by integer division.
    int  m_hits, m_cnt;
    bit  m_lerr;
    logic [NUM_CLASSES-1:0] m_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_CLASSES-1:0] hot(input int l);
        logic [NUM_CLASSES-1:0] one;
        one = 1;
        return (l >= 0 && l < NUM_CLASSES) ? (one << l) : '0;
    endfunction

    task automatic model_reset();
        m_hits = 0; m_cnt = 0; m_lerr = 0; m_exp = '0;
    endtask

    task automatic check_idle_zero(input string pfx);
        chk({pfx, "_ready"}, sb_if.in_ready, 1);
        chk({pfx, "_count"}, count, 0);
        chk({pfx, "_correct"}, correct_count, 0);
        chk({pfx, "_acc"}, accuracy, 0);
        chk({pfx, "_bnext"}, begin_next, 0);
        chk({pfx, "_lerr"}, label_err, 0);
        chk({pfx, "_done"}, all_done, 0);
        chk({pfx, "_exp"}, expected_output, 0);
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (sb_if.in_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", sb_if.in_ready, 1);
    endtask

    // Accept at the next edge, drop valid, then sit at the ncyc-th negedge after acceptance.
    task automatic start_only(input logic [NUM_CLASSES-1:0] obt, input int lbl, input int ncyc);
        wait_ready();
        sb_if.in_valid = 1'b1;
        sb_if.obtained_output = obt;
        sb_if.label = LBL_W'(lbl);
        @(posedge clk);
        @(negedge clk);
        sb_if.in_valid = 1'b0;
        repeat (ncyc - 1) @(negedge clk);
    endtask

    task automatic infer(input logic [NUM_CLASSES-1:0] obt, input int lbl);
        int got, busy_bad;
        start_only(obt, lbl, 1);
        m_cnt++;
        m_exp = hot(lbl);
        if (lbl < NUM_CLASSES && obt == m_exp) m_hits++;
        if (lbl >= NUM_CLASSES) m_lerr = 1;
        got = 0;
        busy_bad = 0;
        for (int k = 1; k <= LAT + 10; k++) begin
            if (k > 1) @(negedge clk);
            if (sb_if.in_ready !== 1'b0) busy_bad++;
            if (begin_next === 1'b1) begin
                got = k;
                break;
            end
        end
        chk("latency", got, LAT);
        chk("ready_low_busy", busy_bad, 0);
        chk("count", count, m_cnt);
        chk("correct", correct_count, m_hits);
        chk("accuracy", accuracy, (m_hits * 100) / m_cnt);
        chk("expected", expected_output, m_exp);
        chk("label_err", label_err, m_lerr);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        chk("clr_count", count, 0);
        chk("clr_acc", accuracy, 0);
        chk("clr_lerr", label_err, 0);
        chk("clr_ready", sb_if.in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, lbl;
        logic [NUM_CLASSES-1:0] obt;
        sb_if.in_valid = 1'b0;
        sb_if.obtained_output = '0;
        sb_if.label = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_idle_zero("rst");
        rst_overall_n = 1'b1;
        @(negedge clk);

        // Labels 0,3,5,9 with the third decision wrong.
        infer(hot(0), 0);
        infer(hot(3), 3);
        infer(hot(4), 5);
        infer(hot(9), 9);
        chk("acc_75", accuracy, 75);

        do_clear();
        infer(hot(1), 1);
        infer(hot(2), 7);
        infer('0, 4);
        chk("acc_33", accuracy, 33);

        do_clear();
        infer(10'b0000000110, 2);
        chk("multi_hot_miss", correct_count, 0);
        infer(hot(3), 12);
        chk("bad_label_err", label_err, 1);
        chk("bad_label_exp", expected_output, 0);

        for (int i = 0; i < 25; i++) begin
            lbl = int'($urandom_range(0, 11));
            obt = ($urandom_range(0, 2) != 0) ? hot(lbl) : NUM_CLASSES'($urandom);
            infer(obt, lbl);
        end

        // Asynchronous reset in the middle of a divide.
        start_only(hot(5), 5, 5);
        #2 rst_overall_n = 1'b0;
        #1 check_idle_zero("midrst");
        @(negedge clk);
        rst_overall_n = 1'b1;
        model_reset();
        @(negedge clk);

        // Clear in the fifth DIVIDE cycle discards the pending result.
        infer(hot(6), 6);
        infer(hot(8), 8);
        start_only(hot(2), 2, 6);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        chk("abort_count", count, 0);
        chk("abort_acc", accuracy, 0);
        chk("abort_ready", sb_if.in_ready, 1);
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (begin_next === 1'b1) pulses++;
        end
        chk("abort_pulse", pulses, 0);

        // Full run to MAX_INPUTS.
        do_clear();
        for (int i = 0; i < MAX_INPUTS; i++) begin
            lbl = int'($urandom_range(0, NUM_CLASSES - 1));
            infer(hot(lbl), lbl);
            if (i < MAX_INPUTS - 1) chk("not_done_yet", all_done, 0);
        end
        @(negedge clk);
        chk("end_done", all_done, 1);
        chk("end_ready", sb_if.in_ready, 0);
        chk("end_acc", accuracy, 100);
        chk("end_count", count, MAX_INPUTS);
        sb_if.in_valid = 1'b1;
        sb_if.obtained_output = hot(4);
        sb_if.label = LBL_W'(4);
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (begin_next === 1'b1) pulses++;
        end
        sb_if.in_valid = 1'b0;
        chk("extra_pulse", pulses, 0);
        chk("extra_count", count, MAX_INPUTS);
        chk("extra_ready", sb_if.in_ready, 0);
        chk("extra_done", all_done, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
